// File: rtl/wb_interconnect_pkg.sv
// Shared definitions for the Wishbone interconnect blocks: scheduler state
// encoding and a width helper.
package wb_interconnect_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sched_state_e;

  // Ceiling log2, never less than 1 so single-entry fields still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_interconnect_sched_if.sv
// Request/grant bundle between the initiators, the target ack and the
// grant scheduler.
interface wb_interconnect_sched_if #(
  parameter int N_REQ    = 2,
  parameter int WEIGHT_W = 4
);
  localparam int ID_W = wb_interconnect_pkg::clog2(N_REQ);

  logic [N_REQ-1:0]          req;
  logic [N_REQ*WEIGHT_W-1:0] weight;
  logic                      ack;
  logic [N_REQ-1:0]          gnt;
  logic [ID_W-1:0]           gnt_id;
  logic                      busy;
  logic                      timeout;

  modport master (
    output req, weight, ack,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, weight, ack,
    output gnt, gnt_id, busy, timeout
  );
endinterface

// File: rtl/wb_interconnect_rr_pick.sv
// Combinational round-robin picker: first set request strictly above
// i_last_id, wrapping, found by scanning a doubled copy of the request vector.
module wb_interconnect_rr_pick
  import wb_interconnect_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last_id,
  output logic [N_REQ-1:0] o_pick,
  output logic [ID_W-1:0]  o_pick_id,
  output logic             o_valid
);

  logic [2*N_REQ-1:0] w_dbl;
  logic               w_found;
  int                 w_idx;

  assign w_dbl = {i_req, i_req};

  always_comb begin
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < 2*N_REQ; i++) begin
      if (!w_found && w_dbl[i] && (i > int'(i_last_id))) begin
        w_found = 1'b1;
        w_idx   = (i >= N_REQ) ? (i - N_REQ) : i;
      end
    end
  end

  assign o_valid   = w_found;
  assign o_pick_id = ID_W'(w_idx);
  assign o_pick    = w_found ? (N_REQ'(1) << w_idx) : '0;

endmodule

// File: rtl/wb_interconnect_sched.sv
// Weighted round-robin grant scheduler for a shared Wishbone target port,
// with per-grant ack credit and a no-ack watchdog.
//
//   state    | meaning
//   ST_IDLE  | gnt=0; pick next requester above last_id
//   ST_GRANT | gnt one-hot; count acks against credit, run watchdog
module wb_interconnect_sched
  import wb_interconnect_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int WEIGHT_W = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  wb_interconnect_sched_if.slave  bus
);

  localparam int ID_W = clog2(N_REQ);
  localparam int WD_W = clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  sched_state_e        r_state, w_state_nxt;
  logic [N_REQ-1:0]    r_gnt, w_gnt_nxt;
  logic [ID_W-1:0]     r_gnt_id, w_gnt_id_nxt;
  logic [ID_W-1:0]     r_last_id, w_last_id_nxt;
  logic [WEIGHT_W-1:0] r_credit, w_credit_nxt;
  logic [WD_W-1:0]     r_wdog, w_wdog_nxt;
  logic                r_timeout, w_timeout_nxt;

  logic [N_REQ-1:0]    w_pick;
  logic [ID_W-1:0]     w_pick_id;
  logic                w_pick_vld;
  logic [WEIGHT_W-1:0] w_wt [N_REQ];
  logic                w_req_cur;
  logic                w_others;

  wb_interconnect_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req     (bus.req),
    .i_last_id (r_last_id),
    .o_pick    (w_pick),
    .o_pick_id (w_pick_id),
    .o_valid   (w_pick_vld)
  );

  // A zero weight still buys one ack per grant.
  for (genvar g = 0; g < N_REQ; g++) begin : g_wt
    assign w_wt[g] = (bus.weight[g*WEIGHT_W +: WEIGHT_W] == '0) ?
                     WEIGHT_W'(1) : bus.weight[g*WEIGHT_W +: WEIGHT_W];
  end

  assign w_req_cur = bus.req[r_gnt_id];
  assign w_others  = |(bus.req & ~r_gnt);

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_last_id_nxt = r_last_id;
    w_credit_nxt  = r_credit;
    w_wdog_nxt    = r_wdog;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt   = ST_GRANT;
          w_gnt_nxt     = w_pick;
          w_gnt_id_nxt  = w_pick_id;
          w_last_id_nxt = w_pick_id;
          w_credit_nxt  = w_wt[w_pick_id];
          w_wdog_nxt    = '0;
        end
      end
      ST_GRANT: begin
        if (!w_req_cur) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end else if (bus.ack && (r_credit == WEIGHT_W'(1))) begin
          if (w_others) begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
          end else begin
            // Sole requester keeps the port with no dead cycle.
            w_credit_nxt = w_wt[r_gnt_id];
            w_wdog_nxt   = '0;
          end
        end else if (bus.ack) begin
          w_credit_nxt = r_credit - WEIGHT_W'(1);
          w_wdog_nxt   = '0;
        end else if ((TIMEOUT != 0) && (r_wdog == WD_LAST)) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = '0;
        end else if (r_wdog != '1) begin
          w_wdog_nxt = r_wdog + WD_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_last_id <= ID_W'(N_REQ - 1);
      r_credit  <= '0;
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_last_id <= w_last_id_nxt;
      r_credit  <= w_credit_nxt;
      r_wdog    <= w_wdog_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = |r_gnt;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_wb_interconnect_sched.sv
// Directed bench for the weighted round-robin grant scheduler.
module tb_wb_interconnect_sched;
  localparam int N  = 4;
  localparam int WW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_interconnect_sched_if #(.N_REQ(N), .WEIGHT_W(WW)) bus ();

  wb_interconnect_sched #(
    .N_REQ    (N),
    .WEIGHT_W (WW),
    .TIMEOUT  (TO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    bus.ack = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.ack    = 1'b0;
    bus.weight = 16'h1111;
    repeat (3) tick();
    n_vec++;
    if (bus.gnt !== 4'b0000) begin
      n_err++; $display("FAIL reset_gnt: got %b expected %b", bus.gnt, 4'b0000);
    end
    n_vec++;
    if (bus.gnt_id !== 2'd0) begin
      n_err++; $display("FAIL reset_gnt_id: got %0d expected %0d", bus.gnt_id, 0);
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b expected %b", bus.busy, 1'b0);
    end
    n_vec++;
    if (bus.timeout !== 1'b0) begin
      n_err++; $display("FAIL reset_timeout: got %b expected %b", bus.timeout, 1'b0);
    end
  endtask

  task automatic test_single();
    rst_n   = 1'b1;
    bus.req = 4'b0001;
    tick();
    n_vec++;
    if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL single_first: got gnt=%b busy=%b expected gnt=0001 busy=1", bus.gnt, bus.busy);
    end
    bus.ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (bus.gnt !== 4'b0001) begin
        n_err++; $display("FAIL single_hold[%0d]: got %b expected %b", i, bus.gnt, 4'b0001);
      end
    end
    bus.req = '0;
    bus.ack = 1'b0;
    tick();
    n_vec++;
    if (bus.gnt !== 4'b0000) begin
      n_err++; $display("FAIL single_release: got %b expected %b", bus.gnt, 4'b0000);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_id [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    bus.weight = 16'h1111;
    do_reset();
    bus.req = 4'b1111;
    bus.ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'(1 << exp_id[i]);
      tick();
      n_vec++;
      if (bus.gnt !== exp_g || bus.gnt_id !== 2'(exp_id[i])) begin
        n_err++; $display("FAIL rr_grant[%0d]: got gnt=%b id=%0d expected gnt=%b id=%0d", i, bus.gnt, bus.gnt_id, exp_g, exp_id[i]);
      end
      tick();
      n_vec++;
      if (bus.gnt !== 4'b0000) begin
        n_err++; $display("FAIL rr_gap[%0d]: got %b expected %b", i, bus.gnt, 4'b0000);
      end
    end
  endtask

  task automatic test_weighted();
    logic [3:0] exp_g [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
    bus.weight = 16'h1113;
    do_reset();
    bus.req = 4'b0011;
    bus.ack = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_vec++;
      if (bus.gnt !== exp_g[i]) begin
        n_err++; $display("FAIL weighted[%0d]: got %b expected %b", i, bus.gnt, exp_g[i]);
      end
    end
  endtask

  task automatic test_early_drop();
    bus.weight = 16'h1511;
    do_reset();
    bus.req = 4'b0100;
    tick();
    n_vec++;
    if (bus.gnt !== 4'b0100) begin
      n_err++; $display("FAIL drop_grant: got %b expected %b", bus.gnt, 4'b0100);
    end
    bus.req = 4'b1100;
    bus.ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (bus.gnt !== 4'b0100) begin
        n_err++; $display("FAIL drop_ack[%0d]: got %b expected %b", i, bus.gnt, 4'b0100);
      end
    end
    bus.req = 4'b1000;
    tick();
    n_vec++;
    if (bus.gnt !== 4'b0000) begin
      n_err++; $display("FAIL drop_release: got %b expected %b", bus.gnt, 4'b0000);
    end
    bus.ack = 1'b0;
    tick();
    n_vec++;
    if (bus.gnt !== 4'b1000 || bus.gnt_id !== 2'd3) begin
      n_err++; $display("FAIL drop_next: got gnt=%b id=%0d expected gnt=1000 id=3", bus.gnt, bus.gnt_id);
    end
  endtask

  task automatic test_watchdog();
    bus.weight = 16'h1111;
    do_reset();
    bus.req = 4'b0010;
    bus.ack = 1'b0;
    tick();
    n_vec++;
    if (bus.gnt !== 4'b0010) begin
      n_err++; $display("FAIL wd_grant: got %b expected %b", bus.gnt, 4'b0010);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      n_vec++;
      if (bus.gnt !== 4'b0010 || bus.timeout !== 1'b0) begin
        n_err++; $display("FAIL wd_wait[%0d]: got gnt=%b to=%b expected gnt=0010 to=0", i, bus.gnt, bus.timeout);
      end
    end
    tick();
    n_vec++;
    if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL wd_expire: got gnt=%b to=%b busy=%b expected gnt=0000 to=1 busy=0", bus.gnt, bus.timeout, bus.busy);
    end
    tick();
    n_vec++;
    if (bus.gnt !== 4'b0010 || bus.timeout !== 1'b0) begin
      n_err++; $display("FAIL wd_regrant: got gnt=%b to=%b expected gnt=0010 to=0", bus.gnt, bus.timeout);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      n_vec++;
      if (bus.gnt !== 4'b0010 || bus.timeout !== 1'b0) begin
        n_err++; $display("FAIL wd2_wait[%0d]: got gnt=%b to=%b expected gnt=0010 to=0", i, bus.gnt, bus.timeout);
      end
    end
    bus.ack = 1'b1;
    tick();
    n_vec++;
    if (bus.gnt !== 4'b0010 || bus.timeout !== 1'b0) begin
      n_err++; $display("FAIL wd_ack_wins: got gnt=%b to=%b expected gnt=0010 to=0", bus.gnt, bus.timeout);
    end
    bus.ack = 1'b0;
    tick();
    n_vec++;
    if (bus.gnt !== 4'b0010 || bus.timeout !== 1'b0) begin
      n_err++; $display("FAIL wd_after_ack: got gnt=%b to=%b expected gnt=0010 to=0", bus.gnt, bus.timeout);
    end
  endtask

  task automatic test_reset_mid_grant();
    bus.weight = 16'h1111;
    do_reset();
    bus.req = 4'b1000;
    tick();
    n_vec++;
    if (bus.gnt !== 4'b1000) begin
      n_err++; $display("FAIL rmg_grant: got %b expected %b", bus.gnt, 4'b1000);
    end
    tick();
    rst_n = 1'b0;
    tick();
    n_vec++;
    if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0 || bus.busy !== 1'b0 || bus.gnt_id !== 2'd0) begin
      n_err++; $display("FAIL rmg_reset: got gnt=%b to=%b busy=%b id=%0d expected gnt=0000 to=0 busy=0 id=0", bus.gnt, bus.timeout, bus.busy, bus.gnt_id);
    end
    rst_n   = 1'b1;
    bus.req = 4'b1001;
    tick();
    n_vec++;
    if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
      n_err++; $display("FAIL rmg_favour0: got gnt=%b id=%0d expected gnt=0001 id=0", bus.gnt, bus.gnt_id);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_weighted();
    test_early_drop();
    test_watchdog();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_interconnect_sched.md
# wb_interconnect_sched

Weighted round-robin grant scheduler for a shared Wishbone target port in the interconnect. It accepts N_REQ initiator requests (cyc) and issues a registered one-hot grant that the interconnect mux uses to steer one initiator to the target. Each grant lasts for a per-initiator burst of up to `weight` acks. A watchdog revokes any grant that sees no ack for TIMEOUT cycles.

## Interface
- N_REQ, 2: number of requesters, 1..16.
- WEIGHT_W, 4: width of each per-requester weight field.
- TIMEOUT, 255: cycles without ack before the grant is revoked; 0 disables the watchdog.
- clock  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- req  input  N_REQ  per-initiator request (initiator cyc).
- weight  input  N_REQ*WEIGHT_W  acks per grant for each requester; field i is bits [i*WEIGHT_W +: WEIGHT_W]; quasi-static; value 0 is treated as 1.
- ack  input  1  target ack for the granted initiator.
- gnt  output  N_REQ  registered one-hot grant, or all zero.
- gnt_id  output  $clog2(N_REQ) (min 1)  index of the granted requester; valid when busy=1.
- busy  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- States: IDLE (gnt=0) and GRANT (gnt one-hot).
- IDLE:
  - If any req is high, select the first requester with req=1 strictly above last_id, wrapping modulo N_REQ.
  - Register gnt, gnt_id and last_id for that requester.
  - Load credit with weight[sel] (0 becomes 1), clear the watchdog count, go to GRANT.
- GRANT, checked in this priority order:
  1. req[gnt_id]=0: release to IDLE. Applies even if ack is high in the same cycle; that ack is ignored.
  2. ack=1 and credit=1:
     - If any other req is high, release to IDLE.
     - Otherwise reload credit with the weight and hold the grant. No dead cycle for a sole requester.
  3. ack=1: decrement credit and clear the watchdog.
  4. TIMEOUT≠0 and watchdog = TIMEOUT-1 with no ack: pulse timeout for one cycle and release to IDLE.
  5. Otherwise increment the watchdog.
- Watchdog: an ack in the expiry cycle wins, meaning no timeout and the count is cleared.
- Releasing always passes through one IDLE cycle with gnt=0, so the mux never switches mid-cycle.
- ack while in IDLE is ignored.
- Widths:
  - credit is WEIGHT_W bits, unsigned.
  - The watchdog is $clog2(TIMEOUT+1) bits and saturates; it never wraps.
  - last_id is gnt_id width.
- Reset values (reset=0 at an edge): state IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, credit=0, watchdog=0, last_id=N_REQ-1 so requester 0 wins first.
- Reset mid-grant drops gnt at the next edge.

## Timing
- Grant latency: req rises with state IDLE at edge k, gnt is high after edge k+1. Requester 0 can win the very first cycle after reset deasserts.
- Release:
  - The release condition is sampled at edge k; gnt=0 after edge k.
  - The next grant appears after edge k+1.
  - Minimum handover is 2 cycles.
- busy equals |gnt, same cycle.
- The timeout pulse is coincident with the first gnt=0 cycle.
- No combinational path from req or ack to gnt.

## Structure
- Shared package `wb_interconnect_pkg`:
  - Scheduler state encoding constants (IDLE=1'b0, GRANT=1'b1).
  - A clog2 helper function, shared with the other interconnect blocks.
- Sub-module `wb_interconnect_rr_pick`:
  - Purely combinational; inputs req and last_id, output one-hot pick plus index.
  - Implemented as a double-width priority search.
  - Reusable by other arbiters in the interconnect.
- Top level: state register, credit counter, watchdog counter, output registers.

## Test plan
- Reset then single requester:
  - Setup: N_REQ=4, weights 1; hold reset=0 for 3 cycles, release, req=4'b0001 continuously.
  - Expected: gnt=0001 one cycle after release; acks every cycle keep gnt stable with no dead cycle.
- Round-robin order: all weights 1, req=4'b1111 held, ack in every GRANT cycle. Expected grant order 0,1,2,3,0, each followed by one gnt=0 cycle.
- Weighted burst: weight={1,1,1,3}, req=4'b0011. Expected: requester 0 receives 3 acks, then requester 1 receives 1, then requester 0 again.
- Early drop:
  - Stimulus: requester 2 granted with weight 5; req[2] falls after 2 acks, coincident with an ack.
  - Expected: gnt=0 next cycle, then the next pending requester above 2 is granted.
- Watchdog:
  - Setup: TIMEOUT=8, req=4'b0010, no ack.
  - Expected: timeout pulses exactly 8 cycles after gnt rises, with gnt=0 in the same cycle and regrant one cycle later.
  - Repeat with ack arriving in cycle 8: expected no timeout.
- Reset mid-grant: assert reset=0 while gnt=1000. Expected gnt=0 and timeout=0 after the next edge; after release, requester 0 is favoured first.
